// File: rtl/neuron_accumulator.sv
// neuron_accumulator
//   Multiply-accumulate stage of a network neuron. Collects NI signed
//   (activation, weight) beats, adds a bias sampled with the first beat,
//   saturates the exact sum to WO bits and presents it on a valid/ready
//   output that never retracts a result.
//
//   Build option: define NEURON_RELU_EN to clamp negative results to zero
//   after saturation. Timing and handshakes are identical in both builds.
module neuron_accumulator #(
  parameter int WI = 8,
  parameter int NI = 4,
  parameter int WO = 16
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iValid_AS,
  output logic            oReady_AS,
  input  logic [2*WI-1:0] iData_AS,
  input  logic [WO-1:0]   iBias,
  output logic            oValid_BS,
  input  logic            iReady_BS,
  output logic [WO-1:0]   oData_BS
);

  // Accumulator is wide enough that bias plus NI full-precision products
  // can never overflow, so saturation only has to look at the final sum.
  localparam int WA = 2*WI + $clog2(NI) + 1;
  localparam int WC = (NI > 1) ? $clog2(NI) : 1;

  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  localparam logic [WC-1:0] CNT_LAST = WC'(NI - 1);
  localparam logic [WO-1:0] SAT_MAX  = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] SAT_MIN  = {1'b1, {(WO-1){1'b0}}};

  logic [0:0]           stateReg;
  logic [WC-1:0]        cntReg;
  logic signed [WA-1:0] accReg;
  logic [WO-1:0]        dataReg;

  logic                   beatAccept;
  logic                   firstBeat;
  logic                   lastBeat;
  logic signed [WI-1:0]   act;
  logic signed [WI-1:0]   wgt;
  logic signed [2*WI-1:0] product;
  logic signed [WA-1:0]   productExt;
  logic signed [WA-1:0]   biasExt;
  logic signed [WA-1:0]   accNext;
  logic [WA-WO:0]         accUpper;
  logic                   posOvf;
  logic                   negOvf;
  logic [WO-1:0]          satResult;
  logic [WO-1:0]          outResult;

  // Input side is ready while collecting, or while a held result is being
  // taken downstream in this same cycle; never during reset.
  always_comb begin
    oReady_AS = 1'b0;
    if (!iRST) begin
      if (stateReg == ST_ACC) begin
        oReady_AS = 1'b1;
      end else begin
        oReady_AS = iReady_BS;
      end
    end
  end

  assign beatAccept = iValid_AS && oReady_AS;

  // In OUT the counter is always zero, so an accepted beat there naturally
  // starts the next vector.
  assign firstBeat = (cntReg == '0);
  assign lastBeat  = (cntReg == CNT_LAST);

  // Full-precision signed product and exact next accumulator value.
  always_comb begin
    act        = iData_AS[2*WI-1:WI];
    wgt        = iData_AS[WI-1:0];
    product    = act * wgt;
    productExt = {{(WA-2*WI){product[2*WI-1]}}, product};
    biasExt    = {{(WA-WO){iBias[WO-1]}}, iBias};
    if (firstBeat) begin
      accNext = biasExt + productExt;
    end else begin
      accNext = accReg + productExt;
    end
  end

  // Saturate to WO bits: the sum fits when every bit above the output sign
  // bit matches it; otherwise clamp towards the sign of the sum.
  always_comb begin
    accUpper = accNext[WA-1:WO-1];
    posOvf   = !accNext[WA-1] && (|accUpper);
    negOvf   = accNext[WA-1] && !(&accUpper);
    if (posOvf) begin
      satResult = SAT_MAX;
    end else if (negOvf) begin
      satResult = SAT_MIN;
    end else begin
      satResult = accNext[WO-1:0];
    end
  end

`ifdef NEURON_RELU_EN
  // Rectify after saturation so the output is never negative.
  always_comb begin
    outResult = satResult[WO-1] ? '0 : satResult;
  end
`else
  // Signed saturated value passes through unchanged.
  always_comb begin
    outResult = satResult;
  end
`endif

  // Beat counting, accumulation and result capture; a held result only
  // leaves OUT through the downstream handshake.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stateReg <= ST_ACC;
      cntReg   <= '0;
      accReg   <= '0;
      dataReg  <= '0;
    end else if (beatAccept) begin
      accReg <= accNext;
      if (lastBeat) begin
        cntReg   <= '0;
        dataReg  <= outResult;
        stateReg <= ST_OUT;
      end else begin
        cntReg   <= cntReg + WC'(1);
        stateReg <= ST_ACC;
      end
    end else if ((stateReg == ST_OUT) && iReady_BS) begin
      stateReg <= ST_ACC;
    end
  end

  assign oValid_BS = (stateReg == ST_OUT);
  assign oData_BS  = dataReg;

endmodule

// File: doc/neuron_accumulator.md
# neuron_accumulator

- Multiply-accumulate stage of a network neuron; sits directly upstream of a valid/ready pipeline register in the neuron datapath.
- Consumes a stream of (activation, weight) pairs, NI pairs per output. Adds a bias and saturates the sum.
- Emits one result per NI accepted beats on a valid/ready output.
- Full-throughput: the next vector's first beat may be accepted in the same cycle the previous result is taken.

## Interface
Parameters:
- WI, 8, width of activation and of weight (signed two's complement)
- NI, 4, beats (products) per output; NI ≥ 1
- WO, 16, output and bias width (signed); 2 ≤ WO ≤ 2*WI
- Derived, not overridable: WA = 2*WI + clog2(NI) + 1, accumulator width; WC = max(1, clog2(NI)), counter width

Ports:
- iCLK  in  1  clock
- iRST  in  1  reset, synchronous, active-high; clock iCLK
- iValid_AS  in  1  upstream beat valid
- oReady_AS  out  1  beat accepted when iValid_AS && oReady_AS
- iData_AS  in  2*WI  {activation[2*WI-1:WI], weight[WI-1:0]}
- iBias  in  WO  bias, sampled on acceptance of a vector's first beat
- oValid_BS  out  1  result valid
- iReady_BS  in  1  downstream ready
- oData_BS  out  WO  saturated result

## Operation
- States:
  - ACC: collecting beats; counter cnt counts 0..NI-1.
  - OUT: result held.
- ACC:
  - oReady_AS = 1.
  - Accepted beat with cnt==0: acc ← sext(iBias) + x*w.
  - Accepted beat with cnt>0: acc ← acc + x*w.
  - cnt increments on every accepted beat.
  - On the NI-th accepted beat (cnt==NI-1): oData_BS ← sat(acc_next), cnt ← 0, state → OUT.
  - NI=1: every accepted beat goes directly to OUT.
- OUT:
  - oValid_BS = 1.
  - oReady_AS = iReady_BS. This is a combinational path; there are no other combinational input-to-output paths.
  - If iReady_BS is high, the result handshake completes.
    - No beat accepted: state → ACC.
    - A beat accepted in the same cycle: it is treated as cnt==0 of the next vector. If NI==1, state stays OUT with the new result; otherwise state → ACC with cnt=1.
  - If iReady_BS is low: oData_BS and oValid_BS are held unchanged and no beat is accepted.
- Arithmetic:
  - Products are full-precision signed 2*WI bits.
  - Accumulation is exact in WA bits; no intermediate overflow is possible.
  - sat(): values > 2^(WO-1)-1 clamp to 2^(WO-1)-1; values < -2^(WO-1) clamp to -2^(WO-1); otherwise the low WO bits.
- Bubbles: cycles with iValid_AS low change nothing. cnt and acc hold.
- Reset:
  - Next edge: state=ACC, cnt=0, acc=0, oValid_BS=0, oData_BS=0.
  - oReady_AS is forced 0 while iRST is high. Beats presented during reset are discarded.
  - A partially accumulated vector is dropped.

## Timing
- Latency: result is valid on oValid_BS in the cycle after the NI-th beat is accepted.
- Sustained throughput: one result per NI cycles with iValid_AS and iReady_BS held high.
- oValid_BS, once asserted, stays high with oData_BS stable until the iReady_BS handshake. AXI-style; no retraction.
- oReady_AS = 1 in the first cycle after iRST deasserts.
- No other state changes occur on cycles without a handshake.

## Configuration
- NEURON_RELU_EN defined: after saturation, negative results are replaced by 0; oData_BS is never negative.
- Undefined: the signed saturated result is passed unchanged.
- Latency and handshake behaviour are identical in both builds.

## Test plan
All cases use default parameters.
- Reset: hold iRST 3 cycles with iValid_AS=1.
  - During reset: oReady_AS=0, oValid_BS=0, oData_BS=0.
  - First cycle after reset: oReady_AS=1. No spurious result.
- Basic vector: iBias=10, beats (1,2),(3,4),(-5,6),(7,-8) back-to-back.
  - Next cycle: oValid_BS=1, oData_BS=-62 (0 with NEURON_RELU_EN).
- Saturation:
  - Four beats (127,127), bias 0 → 32767.
  - Four beats (-128,127), bias 0 → -32768 (0 with NEURON_RELU_EN).
- Backpressure: iReady_BS=0 for 5 cycles after a result.
  - oValid_BS and oData_BS are held; oReady_AS=0; no beats consumed.
  - On release, the result transfers and beat 0 of the next vector is accepted the same cycle.
  - Next result arrives 4 cycles later.
- Bubbles: the basic vector with iValid_AS low for 1–3 cycles between beats → same -62, one cycle after the last beat.
- Reset mid-vector: accept 2 beats, pulse iRST, then send the basic vector → -62. The dropped beats have no effect.
